// File: rtl/dmrs_seq_detector.sv
// Length-12 DMRS sequence-group detector: accumulates per-group phase matches over a
// 12-symbol block, then scans the 30 candidates serially for the best match.
module dmrs_seq_detector #(
  parameter int MATCH_THRESH = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic       in_start,
  input  logic [1:0] in_phase,
  output logic       in_ready,
  output logic       out_valid,
  output logic [4:0] u_hat,
  output logic [3:0] match_cnt,
  output logic       detected
);

  typedef enum logic [1:0] {IDLE, COLLECT, SEARCH, DONE} state_t;

  // Phase codes: +1 -> 00, +3 -> 01, -1 -> 10, -3 -> 11 (shared with the transmit generator)
  localparam logic [1:0] P1 = 2'b00, P3 = 2'b01, M1 = 2'b10, M3 = 2'b11;
  localparam logic [3:0] THRESH = 4'(MATCH_THRESH);

  // Row u holds symbol 0 in the top two bits down to symbol 11 in the bottom two.
  localparam logic [23:0] PHASE_TAB [30] = '{
    {M3,P1,M3,M3,M3,P3,M3,M1,P1,P1,P1,M3},
    {M3,P3,P1,M3,P1,P3,M1,M1,P1,P3,P3,P3},
    {M3,P3,P3,P1,M3,P3,M1,P1,P3,M3,P3,M3},
    {M3,M3,M1,P3,P3,P3,M3,P3,M3,P1,M1,M3},
    {M3,M1,M1,P1,P3,P1,P1,M1,P1,M1,M3,P1},
    {M3,M3,P3,P1,M3,M3,M3,M1,P3,M1,P1,P3},
    {P1,M1,P3,M1,M1,M1,M3,M1,P1,P1,P1,M3},
    {M1,M3,P3,M1,M3,M3,M3,M1,P1,M1,P1,M3},
    {M3,M1,P3,P1,M3,M1,M3,P3,P1,P3,P3,P1},
    {M3,M1,M1,M3,M3,M1,M3,P3,P1,P3,M1,M3},
    {M3,P3,M3,P3,P3,M3,M1,M1,P3,P3,P1,M3},
    {M3,M1,M3,M1,M1,M3,P3,P3,M1,M1,P1,M3},
    {M3,M1,P3,M3,M3,M1,M3,P1,M1,M3,P3,P3},
    {M3,P1,M1,M1,P3,P3,M3,M1,M1,M3,M1,M3},
    {P1,P3,M3,P1,P3,P3,P3,P1,M1,P1,M1,P3},
    {M3,P1,P3,M1,M1,M3,M3,M1,M1,P3,P1,M3},
    {M1,M1,M1,M1,P1,M3,M1,P3,P3,M1,M3,P1},
    {M1,P1,P1,M1,P1,P3,P3,M1,M1,M3,P1,M3},
    {M3,P1,P3,P3,M1,M1,M3,P3,P3,M3,P3,M3},
    {M3,M3,P3,M3,M1,P3,P3,P3,M1,M3,P1,M3},
    {P3,P1,P3,P1,P3,M3,M1,P1,P3,P1,M1,M3},
    {M3,P3,P1,P3,M3,P1,P1,P1,P1,P3,M3,P3},
    {M3,P3,P3,P3,M1,M3,M3,M1,M3,P1,P3,M3},
    {P3,M1,M3,P3,M3,M1,P3,P3,P3,M3,M1,M3},
    {M3,M1,P1,M3,P1,P3,P3,P3,M1,M3,P3,P3},
    {M3,P3,P1,M1,P3,P3,M3,P1,M1,P1,M1,P1},
    {M1,P1,P3,M3,P1,M1,P1,M1,M1,M3,P1,M1},
    {M3,M3,P3,P3,P3,M3,M1,P1,M3,P3,P1,M3},
    {P1,M1,P3,P1,P1,M1,M1,M1,P1,P3,M3,P1},
    {M3,P3,M3,P3,M3,M3,P3,M1,M1,P1,P3,M3}
  };

  function automatic logic [1:0] tab_sym(input logic [4:0] u, input logic [3:0] k);
    logic [23:0] row;
    logic [4:0]  pos;
    row = PHASE_TAB[u];
    pos = {4'd11 - k, 1'b0};
    return row[pos +: 2];
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] c);
    return (c >= 4'd12) ? 4'd12 : c + 4'd1;
  endfunction

  state_t     state, state_nxt;
  logic [3:0] idx;
  logic [3:0] cnt [30];
  logic [4:0] scan_u, best_u, fin_u;
  logic [3:0] best_cnt, cand_cnt, fin_cnt;
  logic       accept, take;

  assign accept   = in_valid & in_ready;
  assign cand_cnt = cnt[scan_u];
  assign take     = cand_cnt > best_cnt;
  assign fin_u    = take ? scan_u : best_u;
  assign fin_cnt  = take ? cand_cnt : best_cnt;

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept && in_start) state_nxt = COLLECT;
      end
      COLLECT: begin
        in_ready = 1'b1;
        if (accept && !in_start && idx == 4'd11) state_nxt = SEARCH;
      end
      SEARCH: if (scan_u == 5'd29) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      scan_u    <= '0;
      best_u    <= '0;
      best_cnt  <= '0;
      u_hat     <= '0;
      match_cnt <= '0;
      detected  <= 1'b0;
      for (int u = 0; u < 30; u++) cnt[u] <= '0;
    end else begin
      state <= state_nxt;
      // A start symbol always restarts the block, whether from IDLE or mid-COLLECT
      if (accept && in_start) begin
        idx <= 4'd1;
        for (int u = 0; u < 30; u++)
          cnt[u] <= (in_phase == tab_sym(5'(u), 4'd0)) ? 4'd1 : 4'd0;
      end else if (accept && state == COLLECT) begin
        idx <= (idx == 4'd11) ? 4'd0 : idx + 4'd1;
        for (int u = 0; u < 30; u++)
          if (in_phase == tab_sym(5'(u), idx)) cnt[u] <= sat_inc(cnt[u]);
      end
      // Strictly-greater replacement keeps the lowest u on ties
      if (state != SEARCH) begin
        scan_u   <= '0;
        best_u   <= '0;
        best_cnt <= '0;
      end else begin
        scan_u <= scan_u + 5'd1;
        if (take) begin
          best_u   <= scan_u;
          best_cnt <= cand_cnt;
        end
        if (scan_u == 5'd29) begin
          u_hat     <= fin_u;
          match_cnt <= fin_cnt;
          detected  <= fin_cnt >= THRESH;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmrs_seq_detector.sv
// Self-checking bench for dmrs_seq_detector: table-driven blocks with a scoreboard
// of expected detections, plus hand-written restart, hold, ignore and reset sequences.
module tb_dmrs_seq_detector;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_start;
  logic [1:0] in_phase;
  logic       in_ready, out_valid, detected;
  logic [4:0] u_hat;
  logic [3:0] match_cnt;

  dmrs_seq_detector #(.MATCH_THRESH(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_start(in_start),
    .in_phase(in_phase), .in_ready(in_ready), .out_valid(out_valid),
    .u_hat(u_hat), .match_cnt(match_cnt), .detected(detected)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference values in the standard's integer form {-3,-1,1,3}
  localparam int TAB [30][12] = '{
    '{-3, 1,-3,-3,-3, 3,-3,-1, 1, 1, 1,-3},
    '{-3, 3, 1,-3, 1, 3,-1,-1, 1, 3, 3, 3},
    '{-3, 3, 3, 1,-3, 3,-1, 1, 3,-3, 3,-3},
    '{-3,-3,-1, 3, 3, 3,-3, 3,-3, 1,-1,-3},
    '{-3,-1,-1, 1, 3, 1, 1,-1, 1,-1,-3, 1},
    '{-3,-3, 3, 1,-3,-3,-3,-1, 3,-1, 1, 3},
    '{ 1,-1, 3,-1,-1,-1,-3,-1, 1, 1, 1,-3},
    '{-1,-3, 3,-1,-3,-3,-3,-1, 1,-1, 1,-3},
    '{-3,-1, 3, 1,-3,-1,-3, 3, 1, 3, 3, 1},
    '{-3,-1,-1,-3,-3,-1,-3, 3, 1, 3,-1,-3},
    '{-3, 3,-3, 3, 3,-3,-1,-1, 3, 3, 1,-3},
    '{-3,-1,-3,-1,-1,-3, 3, 3,-1,-1, 1,-3},
    '{-3,-1, 3,-3,-3,-1,-3, 1,-1,-3, 3, 3},
    '{-3, 1,-1,-1, 3, 3,-3,-1,-1,-3,-1,-3},
    '{ 1, 3,-3, 1, 3, 3, 3, 1,-1, 1,-1, 3},
    '{-3, 1, 3,-1,-1,-3,-3,-1,-1, 3, 1,-3},
    '{-1,-1,-1,-1, 1,-3,-1, 3, 3,-1,-3, 1},
    '{-1, 1, 1,-1, 1, 3, 3,-1,-1,-3, 1,-3},
    '{-3, 1, 3, 3,-1,-1,-3, 3, 3,-3, 3,-3},
    '{-3,-3, 3,-3,-1, 3, 3, 3,-1,-3, 1,-3},
    '{ 3, 1, 3, 1, 3,-3,-1, 1, 3, 1,-1,-3},
    '{-3, 3, 1, 3,-3, 1, 1, 1, 1, 3,-3, 3},
    '{-3, 3, 3, 3,-1,-3,-3,-1,-3, 1, 3,-3},
    '{ 3,-1,-3, 3,-3,-1, 3, 3, 3,-3,-1,-3},
    '{-3,-1, 1,-3, 1, 3, 3, 3,-1,-3, 3, 3},
    '{-3, 3, 1,-1, 3, 3,-3, 1,-1, 1,-1, 1},
    '{-1, 1, 3,-3, 1,-1, 1,-1,-1,-3, 1,-1},
    '{-3,-3, 3, 3, 3,-3,-1, 1,-3, 3, 1,-3},
    '{ 1,-1, 3, 1, 1,-1,-1,-1, 1, 3,-3, 1},
    '{-3, 3,-3, 3,-3,-3, 3,-1,-1, 1, 3,-3}
  };

  typedef struct {
    logic [4:0] u;
    logic [3:0] cnt;
    logic       det;
    bit         chk_lat;
  } exp_t;

  typedef struct {
    int          row;
    logic [11:0] corrupt;
    bit          gaps;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_ov  = 0;
  int   last_acc = 0;

  function automatic logic [1:0] enc(input int v);
    case (v)
      1:       return 2'b00;
      3:       return 2'b01;
      -1:      return 2'b10;
      default: return 2'b11;
    endcase
  endfunction

  function automatic exp_t model(input logic [1:0] s [12]);
    exp_t e;
    int   best;
    best = -1;
    e.u = '0;
    for (int u = 0; u < 30; u++) begin
      int c;
      c = 0;
      for (int k = 0; k < 12; k++) if (enc(TAB[u][k]) == s[k]) c++;
      if (c > best) begin
        best = c;
        e.u  = 5'(u);
      end
    end
    e.cnt = 4'(best);
    e.det = (best >= 10);
    e.chk_lat = 1'b0;
    return e;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      n_ov++;
      if (sb.size() == 0) begin
        check("spurious_out_valid", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("u_hat", int'(u_hat), int'(e.u));
        check("match_cnt", int'(match_cnt), int'(e.cnt));
        check("detected", int'(detected), int'(e.det));
        if (e.chk_lat) check("latency_edges", cyc - last_acc, 30);
      end
    end
  end

  task automatic send_sym(input logic [1:0] ph, input bit st, input bit gaps);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        in_valid = 1'b0;
        in_phase = 2'($urandom_range(0, 3));
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_phase = ph;
    in_start = st;
    if (!in_ready) check("ready_collect", 0, 1);
    @(posedge clk);
    #1;
    last_acc = cyc;
  endtask

  task automatic send_block(input int row, input logic [11:0] corrupt, input bit gaps,
                            input bit push, input bit lat);
    logic [1:0] s [12];
    exp_t e;
    for (int k = 0; k < 12; k++) s[k] = corrupt[k] ? ~enc(TAB[row][k]) : enc(TAB[row][k]);
    if (push) begin
      e = model(s);
      e.chk_lat = lat;
      sb.push_back(e);
    end
    for (int k = 0; k < 12; k++) send_sym(s[k], (k == 0), gaps);
  endtask

  task automatic idle_in();
    @(negedge clk);
    in_valid = 1'b0;
    in_start = 1'b0;
  endtask

  task automatic wait_done();
    int i;
    for (i = 0; i < 80; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      check("result_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [7];
    int   ov0;

    vecs[0] = '{0,  12'h000, 1'b0};
    vecs[1] = '{29, 12'h000, 1'b1};
    vecs[2] = '{29, 12'h021, 1'b0};
    vecs[3] = '{29, 12'h221, 1'b1};
    vecs[4] = '{7,  12'h000, 1'b1};
    vecs[5] = '{22, 12'h000, 1'b0};
    vecs[6] = '{12, 12'h800, 1'b0};

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_start = 1'b0;
    in_phase = 2'b00;
    #13;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_u_hat", int'(u_hat), 0);
    check("rst_match_cnt", int'(match_cnt), 0);
    check("rst_detected", int'(detected), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      send_block(vecs[i].row, vecs[i].corrupt, vecs[i].gaps, 1'b1, !vecs[i].gaps);
      idle_in();
      wait_done();
    end

    // Symbols offered during SEARCH/DONE are ignored and in_ready stays low T+1..T+31
    send_block(0, 12'h000, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i <= 30; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_start = 1'b1;
      in_phase = 2'($urandom_range(0, 3));
      check($sformatf("ready_search_%0d", i), int'(in_ready), 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_start = 1'b0;
    check("ready_back", int'(in_ready), 1);
    check("ignored_search_queue", sb.size(), 0);
    repeat (40) @(negedge clk);

    // Partial block of u=3, then a restart with a full u=17 block
    ov0 = n_ov;
    for (int k = 0; k < 6; k++) send_sym(enc(TAB[3][k]), (k == 0), 1'b0);
    send_block(17, 12'h000, 1'b0, 1'b1, 1'b1);
    idle_in();
    wait_done();
    repeat (40) @(negedge clk);
    check("restart_single_pulse", n_ov - ov0, 1);

    // in_valid held high without in_start yields nothing and outputs hold
    ov0 = n_ov;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_start = 1'b0;
      in_phase = 2'($urandom_range(0, 3));
      if (i % 10 == 0) check("ready_nostart", int'(in_ready), 1);
    end
    idle_in();
    repeat (40) @(negedge clk);
    check("nostart_no_pulse", n_ov - ov0, 0);
    check("hold_u_hat", int'(u_hat), 17);
    check("hold_match_cnt", int'(match_cnt), 12);

    // Reset dropped mid-SEARCH discards the block asynchronously
    ov0 = n_ov;
    send_block(5, 12'h000, 1'b0, 1'b0, 1'b0);
    idle_in();
    repeat (10) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_u_hat", int'(u_hat), 0);
    check("async_rst_match_cnt", int'(match_cnt), 0);
    check("async_rst_detected", int'(detected), 0);
    check("async_rst_out_valid", int'(out_valid), 0);
    check("async_rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("rst_no_pulse", n_ov - ov0, 0);
    send_block(14, 12'h000, 1'b0, 1'b1, 1'b1);
    idle_in();
    wait_done();
    check("after_rst_u_hat", int'(u_hat), 14);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dmrs_seq_detector.md
DMRS_SEQ_DETECTOR -- requirements
Module: dmrs_seq_detector

Interface
REQ-001 SHALL have parameter MATCH_THRESH, default 10: minimum per-symbol match count (0..12) for a positive detection.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  received phase symbol present this cycle.
REQ-005 SHALL have port in_start  input  1  qualifies in_valid; marks symbol index 0 of a 12-symbol block.
REQ-006 SHALL have port in_phase  input  2  received hard-decided phase, in the same 2-bit encoding as the DMRS generator phase table.
REQ-007 SHALL have port in_ready  output  1  block accepts a symbol when in_valid and in_ready are both high.
REQ-008 SHALL have port out_valid  output  1  one-cycle pulse; u_hat, match_cnt and detected are valid.
REQ-009 SHALL have port u_hat  output  5  detected sequence group u, 0..29.
REQ-010 SHALL have port match_cnt  output  4  matching symbols for u_hat, 0..12.
REQ-011 SHALL have port detected  output  1  match_cnt >= MATCH_THRESH.

Function
REQ-012 SHALL hold internally the 30x12 length-12 phase table of TS 38.211 Table 5.2.2.2-2, bit-identical to the transmit generator's table.
REQ-013 SHALL implement states IDLE, COLLECT, SEARCH and DONE.
REQ-014 IDLE: in_ready=1; an accepted symbol with in_start=1 SHALL become index 0, clear all 30 match counters, update them, and go to COLLECT; an accepted symbol with in_start=0 SHALL be dropped.
REQ-015 COLLECT: in_ready=1; an accepted symbol at index k SHALL increment counter[u] for every u where in_phase equals table[u][k], then k increments; in_valid gaps SHALL be tolerated with no state change.
REQ-016 COLLECT: an accepted symbol with in_start=1 SHALL restart the block, clearing the counters and treating that symbol as index 0.
REQ-017 Acceptance of index 11 SHALL move the FSM to SEARCH on the next edge.
REQ-018 SEARCH: in_ready=0; SHALL scan u=0..29, one candidate per cycle (30 cycles), keeping the running maximum; a strictly-greater count replaces the best, so ties resolve to the lowest u.
REQ-019 After the scan: DONE for exactly one cycle with out_valid=1; u_hat/match_cnt/detected driven from the best candidate; in_ready=0; then IDLE.
REQ-020 Latency: index 11 accepted at edge T -> out_valid high in cycle T+31 -> in_ready high again in cycle T+32.
REQ-021 u_hat, match_cnt and detected SHALL hold their last values until the next DONE.
REQ-022 Each match counter SHALL be 4 bits and saturate at 12; no wrap.
REQ-023 Symbols presented while in_ready=0 SHALL be ignored and SHALL NOT be buffered.

Reset
REQ-024 On rst_n low, immediately and regardless of clk: state=IDLE, out_valid=0, u_hat=0, match_cnt=0, detected=0, index=0, all counters=0; in_ready=1 once in IDLE.
REQ-025 Reset asserted mid-COLLECT or mid-SEARCH SHALL discard the partial block with no out_valid.

Verification
REQ-026 Stream row u=0 (11,00,11,11,11,01,11,10,00,00,00,11), back-to-back, in_start on the first symbol -> out_valid at T+31, u_hat=0, match_cnt=12, detected=1.
REQ-027 Stream row u=29 (11,01,11,01,11,11,01,10,10,00,01,11) with random in_valid gaps -> u_hat=29, match_cnt=12, detected=1.
REQ-028 Row u=29 with indices 0 and 5 inverted (00, 00) -> u_hat=29, match_cnt=10, detected=1; same row with indices 0, 5 and 9 corrupted -> match_cnt<=9, detected=0.
REQ-029 Send 6 symbols of u=3, then a new in_start with the full row u=17 -> a single out_valid only, u_hat=17, match_cnt=12.
REQ-030 Drop rst_n during SEARCH -> outputs 0 asynchronously, no out_valid; next full block u=14 -> u_hat=14.
REQ-031 Hold in_valid high with no in_start -> no output; during SEARCH, in_valid symbols are ignored and in_ready=0 for cycles T+1..T+31.
